// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache/memory line arbiter: FSM states,
// grant identifiers and line geometry.
package mem_arbiter_pkg;

   localparam int unsigned BEATS_PER_LINE = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BEAT = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      ARB_GRANT_IC = 1'b0,
      ARB_GRANT_DC = 1'b1
   } arb_grant_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker (bit 0 = icache, bit 1 = dcache).
// Purely combinational; the last-grant pointer is held by the caller.
module mem_arb_rr
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  arb_grant_t last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      if (req[0] && req[1]) begin
         grant = (last_grant == ARB_GRANT_IC) ? 2'b10 : 2'b01;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Line-fill/write-back arbiter: grants one cache at a time and serializes
// its 128-bit line into word beats over a valid/ack memory handshake.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 20,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ic_req,
   input  logic                  ic_we,
   input  logic [ADDR_WIDTH-1:0] ic_addr,
   input  logic [LINE_WIDTH-1:0] ic_wdata,
   output logic                  ic_ready,
   output logic [LINE_WIDTH-1:0] ic_rdata,
   input  logic                  dc_req,
   input  logic                  dc_we,
   input  logic [ADDR_WIDTH-1:0] dc_addr,
   input  logic [LINE_WIDTH-1:0] dc_wdata,
   output logic                  dc_ready,
   output logic [LINE_WIDTH-1:0] dc_rdata,
   output logic                  mem_valid_out,
   output logic                  mem_we_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   output logic [WORD_WIDTH-1:0] mem_wdata_out,
   input  logic                  mem_ack_in,
   input  logic [WORD_WIDTH-1:0] mem_rdata_in
);

   localparam int unsigned BW = $clog2(BEATS_PER_LINE);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_LINE - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BEATS_PER_LINE - 1);

   arb_state_t            state_q, state_d;
   arb_grant_t            id_q, last_q;
   logic                  we_q, abort_q;
   logic [BW-1:0]         beat_q;
   logic [ADDR_WIDTH-1:0] line_addr_q;
   logic [LINE_WIDTH-1:0] wdata_q, rbuf_q, rbuf_next;
   logic [1:0]            grant;
   logic                  granted_req, stop;

   mem_arb_rr u_rr (
      .req        ({dc_req, ic_req}),
      .last_grant (last_q),
      .grant      (grant)
   );

   assign granted_req = (id_q == ARB_GRANT_DC) ? dc_req : ic_req;
   // Once the owner drops its request the transfer ends after the current beat
   assign stop        = abort_q || !granted_req;

   always_comb begin
      rbuf_next = rbuf_q;
      rbuf_next[beat_q*WORD_WIDTH +: WORD_WIDTH] = mem_rdata_in;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (|grant) state_d = ARB_BEAT;
         ARB_BEAT: begin
            if (mem_ack_in) begin
               if (stop)                    state_d = ARB_IDLE;
               else if (beat_q == LAST_BEAT) state_d = ARB_DONE;
            end
         end
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         id_q        <= ARB_GRANT_IC;
         last_q      <= ARB_GRANT_IC;
         we_q        <= 1'b0;
         abort_q     <= 1'b0;
         beat_q      <= '0;
         line_addr_q <= '0;
         wdata_q     <= '0;
         rbuf_q      <= '0;
         ic_rdata    <= '0;
         dc_rdata    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ARB_IDLE: begin
               if (|grant) begin
                  id_q        <= grant[1] ? ARB_GRANT_DC : ARB_GRANT_IC;
                  last_q      <= grant[1] ? ARB_GRANT_DC : ARB_GRANT_IC;
                  we_q        <= grant[1] ? dc_we : ic_we;
                  line_addr_q <= (grant[1] ? dc_addr : ic_addr) & LINE_MASK;
                  wdata_q     <= grant[1] ? dc_wdata : ic_wdata;
                  beat_q      <= '0;
                  abort_q     <= 1'b0;
               end
            end
            ARB_BEAT: begin
               if (!granted_req) abort_q <= 1'b1;
               if (mem_ack_in) begin
                  beat_q <= beat_q + 1'b1;
                  if (!we_q) rbuf_q <= rbuf_next;
                  // Publish the line together with the final beat so rdata is valid with ready
                  if (!we_q && !stop && beat_q == LAST_BEAT) begin
                     if (id_q == ARB_GRANT_DC) dc_rdata <= rbuf_next;
                     else                      ic_rdata <= rbuf_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ic_ready      = (state_q == ARB_DONE) && (id_q == ARB_GRANT_IC);
   assign dc_ready      = (state_q == ARB_DONE) && (id_q == ARB_GRANT_DC);
   assign mem_valid_out = (state_q == ARB_BEAT);
   assign mem_we_out    = mem_valid_out && we_q;
   assign mem_addr_out  = mem_valid_out ? (line_addr_q | ADDR_WIDTH'(beat_q)) : '0;
   assign mem_wdata_out = mem_valid_out ? wdata_q[beat_q*WORD_WIDTH +: WORD_WIDTH] : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and randomized line
// transfers checked against a transaction-level model.
module tb_mem_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         ic_req, ic_we, dc_req, dc_we;
   logic [19:0]  ic_addr, dc_addr;
   logic [127:0] ic_wdata, dc_wdata;
   logic         ic_ready, dc_ready;
   logic [127:0] ic_rdata, dc_rdata;
   logic         mem_valid_out, mem_we_out, mem_ack_in;
   logic [19:0]  mem_addr_out;
   logic [31:0]  mem_wdata_out, mem_rdata_in;

   int unsigned  total = 0;
   int unsigned  bad = 0;
   bit           last_dc;
   logic [127:0] exp_ic_rd, exp_dc_rd;
   logic [31:0]  words [4];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .ic_req        (ic_req),
      .ic_we         (ic_we),
      .ic_addr       (ic_addr),
      .ic_wdata      (ic_wdata),
      .ic_ready      (ic_ready),
      .ic_rdata      (ic_rdata),
      .dc_req        (dc_req),
      .dc_we         (dc_we),
      .dc_addr       (dc_addr),
      .dc_wdata      (dc_wdata),
      .dc_ready      (dc_ready),
      .dc_rdata      (dc_rdata),
      .mem_valid_out (mem_valid_out),
      .mem_we_out    (mem_we_out),
      .mem_addr_out  (mem_addr_out),
      .mem_wdata_out (mem_wdata_out),
      .mem_ack_in    (mem_ack_in),
      .mem_rdata_in  (mem_rdata_in)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, mem_valid_out, 0);
      chk({tag, "_we"}, mem_we_out, 0);
      chk({tag, "_addr"}, mem_addr_out, 0);
      chk({tag, "_wdata"}, mem_wdata_out, 0);
      chk({tag, "_ic_ready"}, ic_ready, 0);
      chk({tag, "_dc_ready"}, dc_ready, 0);
      chk({tag, "_ic_rdata"}, ic_rdata, 0);
      chk({tag, "_dc_rdata"}, dc_rdata, 0);
   endtask

   // One arbitration + line transfer. Called at a negedge with the DUT idle.
   // words[] holds the memory's read beats; wait_cnt stalls beat wait_beat;
   // drop_beat (>=0) withdraws the requests at the start of that beat.
   task automatic do_line(input bit rq_ic, input bit rq_dc, input bit we_ic, input bit we_dc,
                          input logic [19:0] a_ic, input logic [19:0] a_dc,
                          input logic [127:0] wd_ic, input logic [127:0] wd_dc,
                          input int wait_beat, input int wait_cnt, input int drop_beat);
      bit           win_dc, we, aborted;
      logic [19:0]  base;
      logic [127:0] wd, exp_line;
      win_dc  = (rq_ic && rq_dc) ? !last_dc : rq_dc;
      last_dc = win_dc;
      we      = win_dc ? we_dc : we_ic;
      base    = win_dc ? a_dc : a_ic;
      base[1:0] = 2'b00;
      wd      = win_dc ? wd_dc : wd_ic;
      aborted = 1'b0;
      ic_req = rq_ic; ic_we = we_ic; ic_addr = a_ic; ic_wdata = wd_ic;
      dc_req = rq_dc; dc_we = we_dc; dc_addr = a_dc; dc_wdata = wd_dc;
      @(posedge clk);
      for (int b = 0; b < 4 && !aborted; b++) begin
         int nw;
         nw = (b == wait_beat) ? wait_cnt : 0;
         for (int w = 0; w <= nw; w++) begin
            @(negedge clk);
            chk("beat_valid", mem_valid_out, 1);
            chk("beat_we", mem_we_out, we);
            chk("beat_addr", mem_addr_out, base + 20'(b));
            if (we) chk("beat_wdata", mem_wdata_out, wd[32*b +: 32]);
            chk("busy_ic_ready", ic_ready, 0);
            chk("busy_dc_ready", dc_ready, 0);
            if (b == drop_beat && w == 0) begin
               ic_req = 1'b0; dc_req = 1'b0; aborted = 1'b1;
            end
            mem_ack_in   = (w == nw);
            mem_rdata_in = (w == nw) ? words[b] : $urandom;
            @(posedge clk);
         end
      end
      @(negedge clk);
      mem_ack_in = 1'b0;
      if (!aborted) begin
         exp_line = {words[3], words[2], words[1], words[0]};
         if (!we) begin
            if (win_dc) exp_dc_rd = exp_line;
            else        exp_ic_rd = exp_line;
         end
         chk("done_ic_ready", ic_ready, !win_dc);
         chk("done_dc_ready", dc_ready, win_dc);
         chk("done_valid", mem_valid_out, 0);
         chk("done_ic_rdata", ic_rdata, exp_ic_rd);
         chk("done_dc_rdata", dc_rdata, exp_dc_rd);
         ic_req = 1'b0; dc_req = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      chk("idle_valid", mem_valid_out, 0);
      chk("idle_ic_ready", ic_ready, 0);
      chk("idle_dc_ready", dc_ready, 0);
      chk("idle_ic_rdata", ic_rdata, exp_ic_rd);
      chk("idle_dc_rdata", dc_rdata, exp_dc_rd);
   endtask

   initial begin
      reset = 1'b1;
      ic_req = 0; ic_we = 0; ic_addr = '0; ic_wdata = '0;
      dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
      mem_ack_in = 0; mem_rdata_in = '0;
      last_dc = 1'b0; exp_ic_rd = '0; exp_dc_rd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // dcache read, zero-wait memory
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
      do_line(0, 1, 0, 0, '0, 20'h00123, '0, '0, -1, 0, -1);
      chk("dc_line_const", dc_rdata, 128'h00000044_00000033_00000022_00000011);

      // icache write-back
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      do_line(1, 0, 1, 0, 20'h00040, '0, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, '0, -1, 0, -1);

      // reset, then simultaneous requests alternate dc, ic
      @(negedge clk); reset = 1'b1; @(posedge clk); @(negedge clk); reset = 1'b0;
      last_dc = 1'b0; exp_ic_rd = '0; exp_dc_rd = '0;
      chk_all_zero("reset2");
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) words[i] = $urandom;
         do_line(1, 1, 0, 0, 20'h01005, 20'h0A00B, '0, '0, -1, 0, -1);
      end

      // two wait cycles on beat 1
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      do_line(0, 1, 1, 1, '0, 20'hFFFF1, '0, {$urandom, $urandom, $urandom, $urandom}, 1, 2, -1);

      // dcache withdraws during a stalled beat 2
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      do_line(0, 1, 0, 0, '0, 20'h00300, '0, '0, 2, 2, 2);

      // randomized transfers
      for (int n = 0; n < 16; n++) begin
         int r, wb, wc, db;
         r  = $urandom_range(1, 3);
         wb = $urandom_range(0, 3);
         wc = $urandom_range(0, 3);
         db = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
         for (int i = 0; i < 4; i++) words[i] = $urandom;
         do_line((r & 1) != 0, (r & 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 20'($urandom), 20'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 wb, wc, db);
      end

      // reset in the middle of a transfer
      dc_we = 1'b0; dc_addr = 20'h12344; dc_req = 1'b1;
      @(posedge clk);
      @(negedge clk); mem_ack_in = 1'b1; mem_rdata_in = $urandom;
      @(posedge clk);
      @(negedge clk); reset = 1'b1; mem_ack_in = 1'b0; dc_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("midbeat_reset");
      reset = 1'b0;
      last_dc = 1'b0; exp_ic_rd = '0; exp_dc_rd = '0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) words[i] = $urandom;
         do_line(1, 1, 0, 0, 20'h00777, 20'h00888, '0, '0, 3, 1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Line-fill/write-back arbiter between the instruction cache, the data cache and the single word-wide memory port. Accepts 128-bit line read and write requests from both caches, arbitrates round-robin, and serializes each line into four 32-bit beats with a valid/ack handshake on the memory side. On completion it returns a one-cycle ready pulse, with the assembled line for reads, to the granted cache. Sits directly downstream of both cache instances and upstream of the memory controller.

## Interface
- ADDR_WIDTH, 20, word address width shared by caches and memory port
- LINE_WIDTH, 128, cache line width
- WORD_WIDTH, 32, memory beat width; beats per line = LINE_WIDTH/WORD_WIDTH = 4

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ic_req  in  1  icache request
- ic_we  in  1  icache request is a write-back
- ic_addr  in  20  icache line word address
- ic_wdata  in  128  icache write-back line
- ic_ready  out  1  icache transfer complete, one-cycle pulse
- ic_rdata  out  128  filled line, valid while ic_ready
- dc_req, dc_we, dc_addr, dc_wdata, dc_ready, dc_rdata  same as ic_* for the dcache
- mem_valid_out  out  1  beat request to memory
- mem_we_out  out  1  beat is a write
- mem_addr_out  out  20  beat word address
- mem_wdata_out  out  32  beat write data
- mem_ack_in  in  1  memory accepted/completed current beat
- mem_rdata_in  in  32  read beat data, valid with mem_ack_in

## Operation
- States: IDLE, BEAT, DONE.
- IDLE: samples requests. Both requesting: grant goes to the requester not granted last; the pointer resets to favour dcache. Only one requesting: that one wins. On grant: register the requester ID, we, the line address `{addr[19:2],2'b00}` and wdata; clear the beat counter; go to BEAT.
- BEAT: mem_valid_out=1; mem_addr_out={line_addr[19:2], beat}; mem_wdata_out=wdata[32*beat+:32]. On mem_ack_in, a read stores mem_rdata_in into rdata[32*beat+:32], then beat increments. Ack on beat 3 -> DONE.
- DONE: assert granted *_ready for exactly one cycle with *_rdata = assembled line; reads only, since writes return the last held line value and caches ignore it. Next state IDLE unconditionally. Requests are never sampled in DONE, so a req still high during the ready cycle is not re-granted.
- Abort: if the granted requester's req is low in BEAT, the current beat is completed. valid stays until ack because the memory handshake is never broken. Then go to IDLE with no ready pulse. This covers the cache-side reset_mem_req.
- mem_ack_in while mem_valid_out=0 is ignored.
- The non-granted *_ready is always 0. *_rdata holds its last value when not ready.
- Reset (any state, including mid-beat): state IDLE, beat 0, pointer favours dcache. All outputs 0: mem_valid_out, mem_we_out, mem_addr_out, mem_wdata_out, ic_ready, dc_ready, ic_rdata, dc_rdata.

## Timing
- Request seen in IDLE at cycle 0 -> mem_valid_out first high at cycle 1 (registered).
- Zero-wait memory (ack same cycle as valid): beats at cycles 1–4, ready at cycle 5, IDLE at 6. Minimum turnaround is 6 cycles per line.
- Each wait cycle (valid && !ack) extends the transfer by 1. The address and data are stable while waiting.
- Back-to-back beats: valid stays high and the address advances in the cycle after ack.
- A new grant is possible at the earliest in the IDLE cycle after DONE.

## Structure
- Add to definitions.v:
  - ARB_IDLE/ARB_BEAT/ARB_DONE state encodings (2 bits)
  - ARB_GRANT_IC/ARB_GRANT_DC
  - BEATS_PER_LINE
- One natural sub-module: mem_arb_rr, a 2-way round-robin picker. Inputs: req vector, last-grant pointer. Output: one-hot grant. It is combinational; the pointer register lives in mem_arbiter.
- The rest (FSM, beat counter, line buffers) stays in mem_arbiter.

## Test plan
- dc read, addr 0x00123, zero-wait memory returning 0x11,0x22,0x33,0x44 -> addresses 0x00120..0x00123 on cycles 1–4; dc_ready at cycle 5 with dc_rdata=0x00000044_00000033_00000022_00000011.
- ic write-back, addr 0x00040, wdata 0xDDDD_CCCC_BBBB_AAAA (per word) -> 4 write beats with wdata AAAA,BBBB,CCCC,DDDD in order; ic_ready pulse for one cycle.
- ic and dc request together from reset -> dc served first, then ic. Repeat with both requesting -> ic first (alternation).
- Memory inserts 2 wait cycles on beat 1 -> address 0x..1 and its data held 3 cycles; ready arrives 2 cycles later than in the zero-wait case.
- dc_req drops during beat 2 while ack is delayed -> beat 2 completes, no beat 3, no dc_ready, IDLE next. Reset asserted mid-beat -> all outputs 0 next cycle.
